// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-backed FIFO controller.
// Holds the default word/address widths and the depth and pointer-width
// derivations, so the controller and the RAM instantiation agree on sizes.
package ram_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 8;

    // RAM depth for a given address width.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrap-bit FIFO pointer.
// The low bits address the RAM; the MSB toggles on every wrap so that
// full and empty can be told apart when the address bits match.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset, clears the pointer to 0
//   i_inc  - advance the pointer by one at the next edge
//   o_ptr  - current pointer value
module ram_fifo_ptr #(
    parameter int PTR_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc,
    output logic [PTR_WIDTH-1:0] o_ptr
);

    logic [PTR_WIDTH-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PTR_WIDTH'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller in front of an asynchronous-read RAM.
// Producer words are written straight into the RAM; the RAM is drained
// into a single registered output word for the consumer. Total capacity
// is DEPTH words in RAM plus one in the output register.
// Ports:
//   clk, rst                         - clock, async active-low reset
//   in_data/in_valid/in_ready        - producer stream
//   out_data/out_valid/out_ready     - consumer stream (out_data registered)
//   ram_write/ram_write_addr/ram_data_in - RAM write port
//   ram_read_addr/ram_data_out       - RAM async read port
//   count/full/empty                 - RAM occupancy and status
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [PTR_W-1:0]      w_wptr;
    logic [PTR_W-1:0]      w_rptr;
    logic [PTR_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_accept;
    logic                  w_load;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    ram_fifo_ptr #(.PTR_WIDTH(PTR_W)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_accept),
        .o_ptr (w_wptr)
    );

    ram_fifo_ptr #(.PTR_WIDTH(PTR_W)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_load),
        .o_ptr (w_rptr)
    );

    // Modulo subtraction; the wrap bit makes DEPTH distinguishable from 0.
    assign w_count = w_wptr - w_rptr;
    assign w_full  = (w_count == DEPTH_P);

    // in_ready depends only on registered pointers and reset, so a pop
    // frees the slot for the following cycle, never the current one.
    assign in_ready = rst && !w_full;
    assign w_accept = in_valid && in_ready;

    // Load from RAM whenever a word is stored and the output register is
    // empty or being consumed. Uses pre-edge rptr/RAM, so a word written
    // this cycle can never be loaded in the same cycle.
    assign w_load = (w_count != '0) && (!r_out_valid || out_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= ram_data_out;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign ram_write      = w_accept;
    assign ram_write_addr = w_wptr[ADDR_WIDTH-1:0];
    assign ram_data_in    = in_data;
    assign ram_read_addr  = w_rptr[ADDR_WIDTH-1:0];

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign count     = w_count;
    assign full      = w_full;
    assign empty     = (w_count == '0) && !r_out_valid;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          ram_write;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_data_in;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_data_out;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .ram_write      (ram_write),
        .ram_write_addr (ram_write_addr),
        .ram_data_in    (ram_data_in),
        .ram_read_addr  (ram_read_addr),
        .ram_data_out   (ram_data_out),
        .count          (count),
        .full           (full),
        .empty          (empty)
    );

    // Distributed RAM model: synchronous write, asynchronous read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write) mem[ram_write_addr] <= ram_data_in;
    end
    assign ram_data_out = mem[ram_read_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: RAM contents as a queue, plus the output word.
    logic [DW-1:0] mq [$];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] got [$];
    logic          m_ov;
    logic [DW-1:0] m_od;
    int            m_wr;
    int            m_rd;

    logic          obs_ir;
    logic          obs_ov;
    logic [DW-1:0] obs_od;
    logic [AW:0]   obs_cnt;
    logic          obs_full;
    logic          obs_empty;

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_ov = 1'b0;
        m_od = '0;
        m_wr = 0;
        m_rd = 0;
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, output logic acc);
        logic m_ir;
        logic pop;
        logic load;
        logic [DW-1:0] e;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(negedge clk);
        m_ir = (mq.size() < DEPTH);
        obs_ir = in_ready; obs_ov = out_valid; obs_od = out_data;
        obs_cnt = count; obs_full = full; obs_empty = empty;
        chk_val("in_ready", in_ready, m_ir);
        chk_val("count", count, mq.size());
        chk_val("full", full, mq.size() == DEPTH);
        chk_val("empty", empty, (mq.size() == 0) && !m_ov);
        chk_val("full_and_empty", full && empty, 0);
        chk_val("out_valid", out_valid, m_ov);
        if (m_ov) chk_val("out_data", out_data, m_od);
        chk_val("ram_write", ram_write, iv && m_ir);
        if (iv && m_ir) begin
            chk_val("ram_write_addr", ram_write_addr, m_wr % DEPTH);
            chk_val("ram_data_in", ram_data_in, id);
        end
        chk_val("ram_read_addr", ram_read_addr, m_rd % DEPTH);
        acc = iv && m_ir;
        pop = m_ov && ordy;
        if (pop) begin
            e = sb.pop_front();
            chk_val("order", out_data, e);
            got.push_back(out_data);
        end
        if (acc) sb.push_back(id);
        @(posedge clk);
        #1;
        load = (mq.size() > 0) && (!m_ov || ordy);
        if (load) begin
            m_od = mq.pop_front();
            m_ov = 1'b1;
            m_rd++;
        end else if (pop) begin
            m_ov = 1'b0;
        end
        if (acc) begin
            mq.push_back(id);
            m_wr++;
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic ordy);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            step(1'b1, d, ordy, acc);
            n++;
        end
        if (!acc) chk_val("push_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        logic acc;
        int   n;
        n = 0;
        while ((mq.size() > 0 || m_ov) && n < budget) begin
            step(1'b0, '0, 1'b1, acc);
            n++;
        end
        if (mq.size() > 0 || m_ov) chk_val("drain_timeout", 0, 1);
    endtask

    initial begin
        logic acc;
        logic [DW-1:0] exp_drain [5];
        int sent;
        int cyc;

        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h30 + i), 1'b0, acc);
        in_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_val("rst_out_valid", out_valid, 0);
        chk_val("rst_empty", empty, 1);
        chk_val("rst_count", count, 0);
        chk_val("rst_ram_write", ram_write, 0);
        chk_val("rst_in_ready", in_ready, 0);
        chk_val("rst_out_data", out_data, 0);
        chk_val("rst_full", full, 0);
        chk_val("rst_wr_addr", ram_write_addr, 0);
        chk_val("rst_rd_addr", ram_read_addr, 0);
        @(posedge clk);
        #1;
        chk_val("rst_held_ram_write", ram_write, 0);
        model_reset();
        got.delete();
        rst = 1'b1;
        step(1'b0, '0, 1'b0, acc);
        chk_val("post_rst_in_ready", obs_ir, 1);

        // Single word latency
        step(1'b1, 8'hA5, 1'b1, acc);
        chk_val("single_acc", acc, 1);
        step(1'b0, '0, 1'b1, acc);
        chk_val("single_c1_valid", obs_ov, 0);
        step(1'b0, '0, 1'b1, acc);
        chk_val("single_c2_valid", obs_ov, 1);
        chk_val("single_c2_data", obs_od, 8'hA5);
        step(1'b0, '0, 1'b1, acc);
        chk_val("single_c3_empty", obs_empty, 1);

        // Fill to capacity
        for (int i = 1; i <= 5; i++) push_word(DW'(i), 1'b0);
        step(1'b1, 8'h06, 1'b0, acc);
        chk_val("fill_06_held", acc, 0);
        chk_val("fill_in_ready", obs_ir, 0);
        chk_val("fill_full", obs_full, 1);
        chk_val("fill_count", obs_cnt, 4);
        chk_val("fill_out_data", obs_od, 8'h01);

        // Full with a one-cycle pop
        step(1'b1, 8'h06, 1'b1, acc);
        chk_val("fullpop_in_ready", obs_ir, 0);
        got.delete();
        step(1'b1, 8'h06, 1'b0, acc);
        chk_val("fullpop_next_ready", obs_ir, 1);
        chk_val("fullpop_06_acc", acc, 1);
        drain(20);
        exp_drain[0] = 8'h02; exp_drain[1] = 8'h03; exp_drain[2] = 8'h04;
        exp_drain[3] = 8'h05; exp_drain[4] = 8'h06;
        chk_val("drain_len", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk_val("drain_word", got[i], exp_drain[i]);

        // Wrap-around streaming
        got.delete();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(i), 1'b1, acc);
            chk_val("wrap_acc", acc, 1);
            chk_val("wrap_cnt_le1", obs_cnt <= 1, 1);
            if (i >= 2) chk_val("wrap_stream_valid", obs_ov, 1);
        end
        drain(10);
        chk_val("wrap_len", got.size(), 20);
        for (int i = 0; i < 20 && i < got.size(); i++) chk_val("wrap_word", got[i], i);

        // Random backpressure
        got.delete();
        sent = 0;
        cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            logic iv;
            logic orr;
            iv  = ($urandom_range(0, 99) < 60);
            orr = (sent < 500) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 75);
            step(iv, DW'($urandom), orr, acc);
            if (acc) sent++;
            cyc++;
        end
        chk_val("rand_sent", sent, 1000);
        drain(50);
        chk_val("rand_received", got.size(), 1000);
        chk_val("rand_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
